// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus controller and its arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    TURN = 2'd3
  } busState_e;

  localparam int STARVE_MAX_DEFAULT = 3;
  localparam int STARVE_W           = 2;

  // Saturating increment for the fetch starvation counter.
  function automatic logic [STARVE_W-1:0] satInc(input logic [STARVE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb.sv
// Fixed-priority arbiter (load/store first) with a saturating starvation
// counter that hands the bus to a waiting fetch after STARVE_MAX denials.
module mem_arb
  import mem_bus_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grantEn_i,
  input  logic ifReq_i,
  input  logic lsReq_i,
  output logic ifGnt_o,
  output logic lsGnt_o
);

  logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;
  logic                starveHit;
  logic                ifWins;

  assign starveHit = (int'(starveCnt_q) == STARVE_MAX);
  assign ifWins    = ifReq_i && (!lsReq_i || starveHit);
  assign ifGnt_o   = grantEn_i && ifWins;
  assign lsGnt_o   = grantEn_i && lsReq_i && !ifWins;

  // Count only denials that actually left a fetch waiting.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (ifGnt_o) begin
      starveCnt_d = '0;
    end else if (lsGnt_o && ifReq_i) begin
      starveCnt_d = satInc(starveCnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: muxes fetch and load/store ports onto one RAM with
// registered address/write-enable and a shared tristate data bus.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wen_o,
  inout  wire  [DATA_W-1:0] mem_data_io
);

  busState_e         state_q, state_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic              memWen_q, memWen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rdIsLs_q, rdIsLs_d;
  logic              ifRvalid_q, ifRvalid_d;
  logic              lsRvalid_q, lsRvalid_d;
  logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0] lsRdata_q, lsRdata_d;
  logic              grantEn;
  logic              ifGnt, lsGnt;

  // Grants are only offered while out of reset and not in a write or turnaround.
  assign grantEn = rst_n && ((state_q == IDLE) || (state_q == RD));

  mem_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .grantEn_i(grantEn),
    .ifReq_i  (if_req_i),
    .lsReq_i  (ls_req_i),
    .ifGnt_o  (ifGnt),
    .lsGnt_o  (lsGnt)
  );

  always_comb begin
    state_d    = IDLE;
    memAddr_d  = memAddr_q;
    memWen_d   = 1'b0;
    wdata_d    = wdata_q;
    rdIsLs_d   = rdIsLs_q;
    ifRvalid_d = 1'b0;
    lsRvalid_d = 1'b0;
    ifRdata_d  = ifRdata_q;
    lsRdata_d  = lsRdata_q;

    // The RAM presents read data during RD; capture it for the owning port.
    if (state_q == RD) begin
      if (rdIsLs_q) begin
        lsRvalid_d = 1'b1;
        lsRdata_d  = mem_data_io;
      end else begin
        ifRvalid_d = 1'b1;
        ifRdata_d  = mem_data_io;
      end
    end

    case (state_q)
      IDLE, RD: begin
        if (ifGnt) begin
          state_d   = RD;
          memAddr_d = if_addr_i;
          rdIsLs_d  = 1'b0;
        end else if (lsGnt) begin
          state_d   = ls_we_i ? WR : RD;
          memAddr_d = ls_addr_i;
          memWen_d  = ls_we_i;
          wdata_d   = ls_wdata_i;
          rdIsLs_d  = 1'b1;
        end
      end
      WR:      state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      memAddr_q  <= '0;
      memWen_q   <= 1'b0;
      wdata_q    <= '0;
      rdIsLs_q   <= 1'b0;
      ifRvalid_q <= 1'b0;
      lsRvalid_q <= 1'b0;
      ifRdata_q  <= '0;
      lsRdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      memAddr_q  <= memAddr_d;
      memWen_q   <= memWen_d;
      wdata_q    <= wdata_d;
      rdIsLs_q   <= rdIsLs_d;
      ifRvalid_q <= ifRvalid_d;
      lsRvalid_q <= lsRvalid_d;
      ifRdata_q  <= ifRdata_d;
      lsRdata_q  <= lsRdata_d;
    end
  end

  // Release the bus immediately while reset is held, even mid-write.
  assign mem_data_io = (memWen_q && rst_n) ? wdata_q : {DATA_W{1'bz}};

  assign if_gnt_o    = ifGnt;
  assign ls_gnt_o    = lsGnt;
  assign if_rvalid_o = ifRvalid_q;
  assign ls_rvalid_o = lsRvalid_q;
  assign if_rdata_o  = ifRdata_q;
  assign ls_rdata_o  = lsRdata_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wen_o   = memWen_q;

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the memory address width.
REQ-002 Parameter DATA_W, default 4, SHALL set the memory data width.
REQ-003 Parameter STARVE_MAX, default 3, SHALL set the maximum consecutive fetch denials.
REQ-004 clk  input  1  SHALL be the clock; all state updates on rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 if_req / if_addr  input  1 / ADDR_W  SHALL be the instruction-fetch read request and its address.
REQ-007 if_gnt  output  1  SHALL accept the fetch request this cycle.
REQ-008 if_rvalid / if_rdata  output  1 / DATA_W  SHALL return fetch read data.
REQ-009 ls_req / ls_we / ls_addr / ls_wdata  input  1 / 1 / ADDR_W / DATA_W  SHALL be the load/store request, write flag, address and write data.
REQ-010 ls_gnt  output  1  SHALL accept the load/store request this cycle.
REQ-011 ls_rvalid / ls_rdata  output  1 / DATA_W  SHALL return load data; never pulsed for stores.
REQ-012 mem_addr / mem_wen  output  ADDR_W / 1  SHALL drive the RAM address and write-enable, both registered.
REQ-013 mem_data  inout  DATA_W  SHALL be the shared RAM data bus; driven only when mem_wen=1, else 'z.

Function
REQ-014 Handshake: a transfer SHALL occur at a rising edge where req=1 and gnt=1; gnt is combinational from req, state and arbiter; requestor holds req and payload stable until granted.
REQ-015 At most one of if_gnt, ls_gnt SHALL be 1 in any cycle.
REQ-016 FSM states IDLE, RD, WR, TURN: IDLE/RD SHALL grant; WR SHALL go to TURN unconditionally; TURN SHALL grant nothing and go to IDLE.
REQ-017 Transfer at edge N SHALL load mem_addr, mem_wen (=ls_we for load/store, 0 for fetch) and write-data register, entering RD or WR for cycle N+1; no transfer returns to IDLE with mem_wen=0.
REQ-018 Read: mem_data SHALL be sampled at end of cycle N+1; the requesting port's rvalid=1 with rdata in cycle N+2, one cycle only.
REQ-019 Write: RAM commits at end of cycle N+1; cycle N+2 is TURN (bus released, mem_wen=0), so next grant earliest in cycle N+3.
REQ-020 Back-to-back reads SHALL sustain one transfer per cycle.
REQ-021 Arbitration: ls_req SHALL win over if_req unless starve counter equals STARVE_MAX, then if_req wins.
REQ-022 Starve counter (2 bits) SHALL increment, saturating, on each ls grant while if_req=1, and clear on if grant.
REQ-023 rdata outputs SHALL hold last returned value when rvalid=0.
REQ-024 Simultaneous if_req and ls_req with counter below STARVE_MAX SHALL grant ls only; if_req remains pending.
REQ-025 Address arithmetic SHALL be none; addresses pass unchanged, wrap is the RAM's concern.

Reset
REQ-026 rst_n=0 at an edge SHALL set state IDLE, mem_addr=0, mem_wen=0, starve counter 0, if_rvalid=ls_rvalid=0, if_rdata=ls_rdata=0, write-data register 0.
REQ-027 While rst_n=0, if_gnt=ls_gnt=0 and mem_data SHALL be 'z.
REQ-028 Reset during RD SHALL suppress the pending rvalid; reset during WR SHALL drop to IDLE without TURN.

Structure
REQ-029 Package mem_bus_pkg SHALL hold the state enum type and STARVE_MAX default.
REQ-030 Sub-module mem_arb SHALL implement priority selection plus starve counter; FSM, datapath and tristate stay in mem_bus_ctrl.

Verification
REQ-031 Fetch read if_addr=5, mem[5]=4'b1010 -> if_gnt cycle 0, mem_addr=5/mem_wen=0 cycle 1, if_rvalid=1, if_rdata=1010 cycle 2.
REQ-032 Store ls_addr=3, ls_wdata=4'b0110 then load addr 3 -> mem_wen=1 one cycle, TURN cycle, load returns 0110, gnt gap exactly 2 cycles.
REQ-033 if_req and ls_req (loads) held continuously -> grants ls,ls,ls,if repeating; counter 0 after each if grant.
REQ-034 Four consecutive fetch reads addr 0..3 -> four consecutive if_gnt, four consecutive if_rvalid starting 2 cycles after first.
REQ-035 rst_n low in WR cycle then high -> no TURN, mem_wen=0, outputs at reset values, next request granted from IDLE.
REQ-036 Bench monitor every cycle: mem_data never driven by both sides; no X on mem_data when rvalid sampled.
